// File: rtl/multicore_timer_arbiter.sv
// Round-robin arbiter sharing one timer register block among NUM_REQ cores.
// Tracks a single owning core that gets the timer interrupt and write protection.
module multicore_timer_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [3*NUM_REQ-1:0]    req_address,
  input  logic [16*NUM_REQ-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [15:0]             rsp_readdata,
  output logic [NUM_REQ-1:0]      irq_out,
  output logic                    prot_err,
  output logic                    t_chipselect,
  output logic                    t_write_n,
  output logic [2:0]              t_address,
  output logic [15:0]             t_writedata,
  input  logic [15:0]             t_readdata,
  input  logic                    t_irq
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    RESP
  } state_t;

  state_t r_state, w_next;

  logic [IW-1:0]      r_last, r_owner;
  logic               r_ov, r_wr, r_blk;
  logic               r_perr, r_cs, r_wn;
  logic [NUM_REQ-1:0] r_ack;
  logic [2:0]         r_addr;
  logic [15:0]        r_wdata, r_rdata;

  logic [IW-1:0]      w_gidx, w_c;
  logic               w_any, w_wr, w_blk;
  logic [2:0]         w_addr;
  logic [15:0]        w_wd;
  logic [NUM_REQ-1:0] w_irq;

  // Search starts one past the last winner so every core gets a turn.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_c    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_c = IW'((int'(r_last) + k) % NUM_REQ);
      if (!w_any && req_valid[w_c]) begin
        w_any  = 1'b1;
        w_gidx = w_c;
      end
    end
  end

  always_comb begin
    w_wr   = 1'b0;
    w_addr = '0;
    w_wd   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == IW'(i)) begin
        w_wr   = req_write[i];
        w_addr = req_address[3*i +: 3];
        w_wd   = req_writedata[16*i +: 16];
      end
    end
  end

  // Low half of the map (0..3) is owner-protected.
  assign w_blk = w_wr && r_ov && (r_owner != w_gidx) && !w_addr[2];

  always_comb begin
    w_irq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_irq[i] = t_irq && r_ov && (r_owner == IW'(i));
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = r_wr ? IDLE : RDWAIT;
      RDWAIT:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Timer strobes and acks are registered one state ahead of where they show.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last  <= IW'(NUM_REQ - 1);
      r_owner <= '0;
      r_ov    <= 1'b0;
      r_wr    <= 1'b0;
      r_blk   <= 1'b0;
      r_perr  <= 1'b0;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_ack   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_ack  <= '0;
      r_perr <= 1'b0;
      r_cs   <= 1'b0;
      r_wn   <= 1'b1;
      if (r_state == IDLE && w_any) begin
        r_last  <= w_gidx;
        r_wr    <= w_wr;
        r_addr  <= w_addr;
        r_wdata <= w_wd;
        r_blk   <= w_blk;
        r_cs    <= !w_blk;
        r_wn    <= !w_wr;
        if (w_wr) begin
          r_ack[w_gidx] <= 1'b1;
          r_perr        <= w_blk;
        end
      end
      if (r_state == ISSUE && r_wr && !r_blk && r_addr == 3'd1) begin
        if (r_wdata[0]) begin
          r_owner <= r_last;
          r_ov    <= 1'b1;
        end else if (r_ov && r_owner == r_last) begin
          r_ov <= 1'b0;
        end
      end
      if (r_state == RDWAIT) begin
        r_rdata       <= t_readdata;
        r_ack[r_last] <= 1'b1;
      end
    end
  end

  assign req_ack      = r_ack;
  assign rsp_readdata = r_rdata;
  assign irq_out      = w_irq;
  assign prot_err     = r_perr;
  assign t_chipselect = r_cs;
  assign t_write_n    = r_wn;
  assign t_address    = r_addr;
  assign t_writedata  = r_wdata;

endmodule

// File: tb/tb_multicore_timer_arbiter.sv
// Scoreboard bench: transaction-level model predicts grant order, acks,
// timer accesses, ownership and irq routing for random and directed traffic.
module tb_multicore_timer_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [3*N-1:0]  req_address = '0;
  logic [16*N-1:0] req_writedata = '0;
  logic [N-1:0]    req_ack;
  logic [15:0]     rsp_readdata;
  logic [N-1:0]    irq_out;
  logic            prot_err;
  logic            t_chipselect;
  logic            t_write_n;
  logic [2:0]      t_address;
  logic [15:0]     t_writedata;
  logic [15:0]     t_readdata;
  logic            t_irq = 1'b0;

  multicore_timer_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_ack(req_ack), .rsp_readdata(rsp_readdata),
    .irq_out(irq_out), .prot_err(prot_err),
    .t_chipselect(t_chipselect), .t_write_n(t_write_n),
    .t_address(t_address), .t_writedata(t_writedata),
    .t_readdata(t_readdata), .t_irq(t_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  a;
    logic [15:0] d;
  } op_t;

  typedef struct packed {
    logic [1:0]  core;
    logic        w;
    logic        blk;
    logic [15:0] rd;
    logic [31:0] cyc;
  } exp_t;

  op_t  cq[N][$];
  op_t  mq[N][$];
  exp_t ackq[$];
  op_t  tq[$];

  logic [15:0] tmem[8];
  logic [15:0] mmem[8];
  int mlast = N - 1;
  int mown = 0;
  bit mov = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  exp_t e;
  op_t  ta;

  // Behavioural timer slave
  assign t_readdata = tmem[t_address];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (t_chipselect && !t_write_n) tmem[t_address] = t_writedata;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic op_t mk(bit w, bit [2:0] a, bit [15:0] d);
    op_t o;
    o.w = w;
    o.a = a;
    o.d = d;
    return o;
  endfunction

  // Reference: serve pending cores round-robin, one op at a time.
  function automatic void model(int start);
    int t;
    int c;
    int j;
    op_t o;
    exp_t x;
    bit blk;
    t = start;
    while (1) begin
      c = -1;
      for (int k = 1; k <= N; k++) begin
        j = (mlast + k) % N;
        if (c < 0 && mq[j].size() > 0) c = j;
      end
      if (c < 0) break;
      o = mq[c].pop_front();
      mlast = c;
      blk = o.w && mov && (mown != c) && (o.a < 4);
      x.core = 2'(c);
      x.w = o.w;
      x.blk = blk;
      x.rd = '0;
      if (o.w) begin
        if (!blk) begin
          mmem[o.a] = o.d;
          tq.push_back(o);
          if (o.a == 3'd1) begin
            if (o.d[0]) begin
              mown = c;
              mov = 1'b1;
            end else if (mov && mown == c) begin
              mov = 1'b0;
            end
          end
        end
        x.cyc = 32'(t + 1);
        t += 2;
      end else begin
        tq.push_back(o);
        x.rd = mmem[o.a];
        x.cyc = 32'(t + 3);
        t += 4;
      end
      ackq.push_back(x);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (req_ack != '0) begin
      if (ackq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack=%b, none outstanding", req_ack);
      end else begin
        e = ackq.pop_front();
        chk("ack_onehot", 32'(req_ack), 32'(1) << e.core);
        chk("ack_prot_err", 32'(prot_err), 32'(e.blk));
        chk("ack_cycle", 32'(cyc), e.cyc);
        if (!e.w) chk("readdata", 32'(rsp_readdata), 32'(e.rd));
      end
    end else if (reset_n) begin
      chk("prot_err_quiet", 32'(prot_err), 32'(0));
    end
    if (t_chipselect) begin
      if (tq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_cs: got addr=%0d write_n=%b", t_address, t_write_n);
      end else begin
        ta = tq.pop_front();
        chk("t_address", 32'(t_address), 32'(ta.a));
        chk("t_write_n", 32'(t_write_n), 32'(!ta.w));
        if (ta.w) chk("t_writedata", 32'(t_writedata), 32'(ta.d));
      end
    end
  end

  task automatic present(int c);
    if (cq[c].size() > 0) begin
      req_valid[c] = 1'b1;
      req_write[c] = cq[c][0].w;
      req_address[3*c +: 3] = cq[c][0].a;
      req_writedata[16*c +: 16] = cq[c][0].d;
    end else begin
      req_valid[c] = 1'b0;
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int c = 0; c < N; c++) if (cq[c].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_phase(string nm);
    int budget;
    @(negedge clk);
    for (int c = 0; c < N; c++) mq[c] = cq[c];
    model(cyc);
    for (int c = 0; c < N; c++) present(c);
    budget = 0;
    while (pending() && budget < 400) begin
      @(negedge clk);
      budget++;
      for (int c = 0; c < N; c++) begin
        if (req_ack[c] && cq[c].size() > 0) begin
          void'(cq[c].pop_front());
          present(c);
        end
      end
    end
    repeat (3) @(negedge clk);
    if (budget >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got pending requests, required all acked", nm);
      for (int c = 0; c < N; c++) cq[c].delete();
      req_valid = '0;
    end
    chk({nm, "_drained"}, 32'(ackq.size() + tq.size()), 32'(0));
    ackq.delete();
    tq.delete();
  endtask

  task automatic check_irq(string nm);
    logic [N-1:0] x;
    #1;
    x = (t_irq && mov) ? N'(1 << mown) : '0;
    chk(nm, 32'(irq_out), 32'(x));
  endtask

  task automatic check_reset_outputs();
    chk("rst_ack", 32'(req_ack), 32'(0));
    chk("rst_rdata", 32'(rsp_readdata), 32'(0));
    chk("rst_prot", 32'(prot_err), 32'(0));
    chk("rst_cs", 32'(t_chipselect), 32'(0));
    chk("rst_wn", 32'(t_write_n), 32'(1));
    chk("rst_addr", 32'(t_address), 32'(0));
    chk("rst_wdata", 32'(t_writedata), 32'(0));
    chk("rst_irq", 32'(irq_out), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    t_irq = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    req_valid = '0;
    mlast = N - 1;
    mov = 1'b0;
    mown = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    t_irq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tmem[i] = 16'($urandom);
    end
    tmem[2] = 16'd11927;
    for (int i = 0; i < 8; i++) mmem[i] = tmem[i];

    #1;
    do_reset();

    // Single read of period_l by core 2
    cq[2].push_back(mk(1'b0, 3'd2, 16'h0));
    run_phase("single_read");

    // Contention: all cores write, core 0 re-requests
    do_reset();
    cq[0].push_back(mk(1'b1, 3'd4, 16'h1111));
    cq[0].push_back(mk(1'b1, 3'd5, 16'h5555));
    cq[1].push_back(mk(1'b1, 3'd5, 16'h2222));
    cq[2].push_back(mk(1'b1, 3'd6, 16'h3333));
    cq[3].push_back(mk(1'b1, 3'd7, 16'h4444));
    run_phase("contention");

    // Ownership and irq routing
    cq[1].push_back(mk(1'b1, 3'd1, 16'h0007));
    run_phase("own_set");
    t_irq = 1'b1;
    check_irq("irq_owner1");
    cq[1].push_back(mk(1'b1, 3'd1, 16'h0000));
    run_phase("own_clr");
    check_irq("irq_cleared");

    // Protection
    cq[1].push_back(mk(1'b1, 3'd1, 16'h0001));
    run_phase("own_again");
    cq[3].push_back(mk(1'b1, 3'd0, 16'hBEEF));
    cq[3].push_back(mk(1'b0, 3'd0, 16'h0));
    run_phase("protect");
    check_irq("irq_after_protect");

    // Reset during RDWAIT
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_address[3 +: 3] = 3'd5;
    tq.push_back(mk(1'b0, 3'd5, 16'h0));
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    req_valid = '0;
    mlast = N - 1;
    mov = 1'b0;
    mown = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("abort_no_ack", 32'(ackq.size() + tq.size()), 32'(0));
    tq.delete();
    for (int c = 0; c < N; c++) cq[c].push_back(mk(1'b1, 3'(4 + c), 16'(c)));
    run_phase("post_reset");

    // Random traffic
    for (int p = 0; p < 40; p++) begin
      for (int c = 0; c < N; c++) begin
        int cnt;
        cnt = $urandom_range(0, 2);
        for (int k = 0; k < cnt; k++) begin
          bit w;
          bit [2:0] a;
          bit [15:0] d;
          w = ($urandom_range(0, 9) < 6);
          a = ($urandom_range(0, 9) < 4) ? 3'd1 : 3'($urandom_range(0, 7));
          d = 16'($urandom);
          cq[c].push_back(mk(w, a, d));
        end
      end
      run_phase("random");
      t_irq = 1'($urandom);
      check_irq("irq_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicore_timer_arbiter.md
MULTICORE_TIMER_ARBITER -- requirements
Module: multicore_timer_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of requesting cores (2..8); IW = clog2(NUM_REQ).
REQ-002 SHALL have port: clk  in  1  clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-003 SHALL have port: reset_n  in  1  async active-low reset.
REQ-004 SHALL have ports: req_valid  in  NUM_REQ  per-core request; req_write  in  NUM_REQ  1=write, 0=read.
REQ-005 SHALL have ports: req_address  in  3*NUM_REQ  packed register address; req_writedata  in  16*NUM_REQ  packed write data.
REQ-006 SHALL have ports: req_ack  out  NUM_REQ  one-cycle completion pulse; rsp_readdata  out  16  read result.
REQ-007 SHALL have ports: irq_out  out  NUM_REQ  routed timer interrupt; prot_err  out  1  blocked-write pulse.
REQ-008 SHALL have timer-side ports: t_chipselect, t_write_n, t_address[2:0], t_writedata[15:0] (out); t_readdata[15:0], t_irq (in).

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, RDWAIT, RESP.
REQ-010 IDLE: if any req_valid set, SHALL grant round-robin starting at last_grant+1 mod NUM_REQ, latch index/write/address/writedata, update last_grant, go ISSUE; otherwise stay IDLE.
REQ-011 ISSUE: SHALL drive t_chipselect=1, t_address, t_writedata, t_write_n=~write from latched values for exactly one cycle; all other cycles t_chipselect=0, t_write_n=1.
REQ-012 ISSUE with write: SHALL assert req_ack[grant] in that cycle, then return to IDLE (2 cycles per write).
REQ-013 ISSUE with read: SHALL go RDWAIT; RDWAIT SHALL capture t_readdata into rsp_readdata, go RESP; RESP SHALL assert req_ack[grant], return to IDLE (4 cycles per read).
REQ-014 rsp_readdata SHALL hold its value until the next RDWAIT capture.
REQ-015 req_ack SHALL be registered, one-hot or zero, high at most one cycle per transaction.
REQ-016 Requesters hold req_valid and fields stable until ack; req_valid changes while not granted SHALL have no effect on an in-flight transaction.
REQ-017 Ownership: completed write to address 1 with writedata[0]=1 SHALL set owner=grant, owner_valid=1; write to address 1 with writedata[0]=0 from the owner SHALL clear owner_valid.
REQ-018 Protection: when owner_valid=1, writes from a non-owner to addresses 0, 1, 2 or 3 SHALL be blocked: t_chipselect stays 0 in ISSUE, req_ack still pulses, prot_err pulses that same cycle, and ownership is unchanged.
REQ-019 Reads and writes to addresses 4..7 SHALL never be blocked.
REQ-020 irq_out[i] SHALL equal t_irq && owner_valid && (owner==i), combinational.
REQ-021 Width rules: index arithmetic SHALL wrap modulo NUM_REQ; no data transformation, 16-bit pass-through.

Reset
REQ-022 On reset_n low, the block SHALL, asynchronously: state=IDLE, last_grant=NUM_REQ-1 (core 0 wins first), owner_valid=0, owner=0, rsp_readdata=0, req_ack=0, prot_err=0, t_chipselect=0, t_write_n=1, t_address=0, t_writedata=0.
REQ-023 Reset mid-transaction SHALL abort with no ack and no timer access; the first grant after release SHALL follow REQ-010.

Verification
REQ-024 Single read: core 2 reads address 2 after reset (period_l=11927) -> one t_chipselect cycle with write_n=1; req_ack[2] pulses in cycle 4 with rsp_readdata=0x2E97.
REQ-025 Contention: all four cores assert req_valid writes simultaneously -> grants in order 0,1,2,3, each ack 2 cycles apart; a re-request by core 0 is granted only after core 3.
REQ-026 Ownership/irq: core 1 writes address 1 data 0x0007 -> owner=1; t_irq=1 -> irq_out=4'b0010; core 1 writes address 1 data 0x0000 -> irq_out=0.
REQ-027 Protection: with owner=1, core 3 writes address 0 -> no t_chipselect, req_ack[3] and prot_err pulse together; core 3 reads address 0 -> forwarded normally.
REQ-028 Reset during RDWAIT -> no req_ack, all outputs at reset values; after release core 0 is granted first.
